// File: rtl/sbox_share_arb.sv
// Shared 4-bit S-box with a four-requester burst-limited round-robin arbiter.
// A single table lookup is registered into a one-entry output stage that
// supports back-to-back accepts while the consumer drains.
module sbox_share_arb #(
    parameter int unsigned BURST = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  req,
    input  logic [15:0] din,
    output logic [3:0]  gnt,
    output logic [3:0]  dout,
    output logic [1:0]  dout_id,
    output logic        dout_valid,
    input  logic        dout_ready
);

    localparam logic [2:0] BurstMax = 3'(BURST);

    typedef enum logic {StIdle, StOwn} state_e;

    state_e     state_q, state_d;
    logic [1:0] owner_q, owner_d;
    logic [1:0] ptr_q, ptr_d;
    logic [2:0] burst_cnt_q, burst_cnt_d;

    logic [3:0] dout_q;
    logic [1:0] dout_id_q;
    logic       dout_valid_q;

    logic       accept;
    logic [1:0] winner;
    logic [1:0] rr_start;
    logic [1:0] rr_win;
    logic [3:0] others;
    logic       keep_owner;
    logic [3:0] sel_nib;
    logic [3:0] sbox_out;

    // Fixed substitution table; the only instance in the block.
    function automatic logic [3:0] sbox(input logic [3:0] x);
        logic [3:0] y;
        unique case (x)
            4'h0: y = 4'h0;
            4'h1: y = 4'h3;
            4'h2: y = 4'h6;
            4'h3: y = 4'h7;
            4'h4: y = 4'hC;
            4'h5: y = 4'hF;
            4'h6: y = 4'hE;
            4'h7: y = 4'hD;
            4'h8: y = 4'hA;
            4'h9: y = 4'hF;
            4'hA: y = 4'hE;
            4'hB: y = 4'hD;
            4'hC: y = 4'hA;
            4'hD: y = 4'h8;
            4'hE: y = 4'h9;
            default: y = 4'hB;
        endcase
        return y;
    endfunction

    // Winner selection: owner keeps the table until its burst is used up,
    // or beyond that when nobody else is asking; otherwise round-robin.
    always_comb begin
        accept     = (|req) && (!dout_valid_q || dout_ready);
        others     = req & ~(4'b0001 << owner_q);
        keep_owner = (state_q == StOwn) && req[owner_q] &&
                     ((burst_cnt_q < BurstMax) || (others == 4'b0000));
        rr_start   = (state_q == StOwn) ? owner_q + 2'd1 : ptr_q;
        rr_win     = rr_start;
        // Descending scan so the closest requester to rr_start wins.
        for (int k = 3; k >= 0; k--) begin
            if (req[rr_start + 2'(k)]) begin
                rr_win = rr_start + 2'(k);
            end
        end
        winner   = keep_owner ? owner_q : rr_win;
        sel_nib  = din[{winner, 2'b00} +: 4];
        sbox_out = sbox(sel_nib);
    end

    // Arbiter state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            owner_q     <= 2'd0;
            ptr_q       <= 2'd0;
            burst_cnt_q <= 3'd0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            ptr_q       <= ptr_d;
            burst_cnt_q <= burst_cnt_d;
        end
    end

    // Arbiter next state: new owner on accept, fall back to idle on an empty request cycle.
    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        ptr_d       = ptr_q;
        burst_cnt_d = burst_cnt_q;
        if (accept) begin
            state_d = StOwn;
            owner_d = winner;
            ptr_d   = winner + 2'd1;
            if ((state_q == StIdle) || (winner != owner_q)) begin
                burst_cnt_d = 3'd1;
            end else if (burst_cnt_q < BurstMax) begin
                burst_cnt_d = burst_cnt_q + 3'd1;
            end
        end else if (req == 4'b0000) begin
            state_d     = StIdle;
            burst_cnt_d = 3'd0;
        end
    end

    // Grant strobe; forced low while reset is asserted.
    always_comb begin
        gnt = 4'b0000;
        if (rst_n && accept) begin
            gnt[winner] = 1'b1;
        end
    end

    // Result register: load on accept, clear valid on a drain without a new accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout_q       <= 4'h0;
            dout_id_q    <= 2'd0;
            dout_valid_q <= 1'b0;
        end else if (accept) begin
            dout_q       <= sbox_out;
            dout_id_q    <= winner;
            dout_valid_q <= 1'b1;
        end else if (dout_ready) begin
            dout_valid_q <= 1'b0;
        end
    end

    assign dout       = dout_q;
    assign dout_id    = dout_id_q;
    assign dout_valid = dout_valid_q;

endmodule
